// File: rtl/ws_ddr_arbiter.sv
// ws_ddr_arbiter
//   Two-master wishbone arbiter that shares one DDR3 wishbone wrapper
//   between the L2 cache (master 0) and a DMA requester (master 1).
//
//   A grant is held for as long as the owning master keeps its cyc high.
//   This means a locked read-modify-write is never split by the other
//   master. When the owner releases cyc, the next grant is chosen in the
//   same cycle, so a waiting master is handed the bus without an IDLE gap.
//
//   While a grant is active, the request side is a combinational mux of
//   the owning master's live signals. Because of this, dropping cyc
//   (abort) or asserting reset removes s_cyc/s_stb immediately. An s_ack
//   that arrives while no master owns the bus is discarded.
//
// Configuration
//   WS_ARB_ROUND_ROBIN_EN  defined   : on simultaneous requests, the master
//                                      that was not granted last wins.
//                          undefined : master 0 always wins simultaneous
//                                      requests.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   m0_addr/din/dm/cyc/stb/we       master 0 request
//   m0_ack, m0_dout                 master 0 acknowledge / read data
//   m1_*                            same set of signals for master 1
//   s_addr/din/dm/cyc/stb/we        request to the DDR3 wrapper
//   s_ack, s_dout                   acknowledge / read data from the wrapper
//   dbg_grant                       00 IDLE, 01 GRANT0, 10 GRANT1
module ws_ddr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int DM_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  input  logic [DM_WIDTH-1:0]   m0_dm,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_dout,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  input  logic [DM_WIDTH-1:0]   m1_dm,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_dout,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_din,
  output logic [DM_WIDTH-1:0]   s_dm,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  input  logic                  s_ack,
  input  logic [DATA_WIDTH-1:0] s_dout,
  output logic [1:0]            dbg_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state;
  state_t state_next;
  state_t arb_state;
  logic   last_grant;

  // Arbitration result, evaluated from the current cyc lines.
  // It is only used when the bus is free or the owner has just released it.
  always_comb begin
    arb_state = IDLE;
    if (m0_cyc && m1_cyc) begin
`ifdef WS_ARB_ROUND_ROBIN_EN
      arb_state = last_grant ? GRANT0 : GRANT1;
`else
      arb_state = GRANT0;
`endif
    end else if (m0_cyc) begin
      arb_state = GRANT0;
    end else if (m1_cyc) begin
      arb_state = GRANT1;
    end
  end

`ifndef WS_ARB_ROUND_ROBIN_EN
  // Fixed priority never consults last_grant. It is still tracked, so that
  // both builds keep the same register state.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // The owner keeps the bus while its cyc stays high.
  // The other master's request never pre-empts the current owner.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = arb_state;
      GRANT0:  state_next = m0_cyc ? GRANT0 : arb_state;
      GRANT1:  state_next = m1_cyc ? GRANT1 : arb_state;
      default: state_next = IDLE;
    endcase
  end

  // State register and record of the most recently granted master.
  // last_grant resets to 1, so that master 0 wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == GRANT0) begin
        last_grant <= 1'b0;
      end else if (state_next == GRANT1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Request mux and ack routing.
  // Reset forces IDLE outputs asynchronously, so an in-flight strobe
  // disappears even before the state register has been cleared.
  always_comb begin
    s_addr = '0;
    s_din  = '0;
    s_dm   = '0;
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    s_we   = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    if (rstn) begin
      case (state)
        GRANT0: begin
          s_addr = m0_addr;
          s_din  = m0_din;
          s_dm   = m0_dm;
          s_cyc  = m0_cyc;
          s_stb  = m0_stb;
          s_we   = m0_we;
          m0_ack = s_ack;
        end
        GRANT1: begin
          s_addr = m1_addr;
          s_din  = m1_din;
          s_dm   = m1_dm;
          s_cyc  = m1_cyc;
          s_stb  = m1_stb;
          s_we   = m1_we;
          m1_ack = s_ack;
        end
        default: begin
          s_cyc = 1'b0;
        end
      endcase
    end
  end

  // Read data is broadcast to both masters; only the ack qualifies it.
  assign m0_dout   = s_dout;
  assign m1_dout   = s_dout;
  assign dbg_grant = rstn ? state : IDLE;

endmodule

// File: doc/ws_ddr_arbiter.md
WS_DDR_ARBITER -- requirements
Module: ws_ddr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, 512, data width of all ports.
REQ-003 SHALL have parameter DM_WIDTH, DATA_WIDTH/8, byte-mask width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports m0_addr/m0_din/m0_dm  input  ADDR_WIDTH/DATA_WIDTH/DM_WIDTH  master 0 (L2 cache) request address, write data, byte mask.
REQ-007 SHALL have ports m0_cyc/m0_stb/m0_we  input  1 each  master 0 bus cycle, strobe, write enable.
REQ-008 SHALL have ports m0_ack  output  1 and m0_dout  output  DATA_WIDTH  master 0 acknowledge and read data.
REQ-009 SHALL have m1_addr, m1_din, m1_dm, m1_cyc, m1_stb, m1_we, m1_ack, m1_dout, identical to m0_* for master 1 (DMA requester).
REQ-010 SHALL have ports s_addr/s_din/s_dm/s_cyc/s_stb/s_we  output  ADDR_WIDTH/DATA_WIDTH/DM_WIDTH/1/1/1  request to the DDR3 wishbone wrapper.
REQ-011 SHALL have ports s_ack  input  1 and s_dout  input  DATA_WIDTH  DDR3 wrapper acknowledge and read data.
REQ-012 SHALL have port dbg_grant  output  2  current state: 00 IDLE, 01 GRANT0, 10 GRANT1.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, GRANT0, GRANT1.
REQ-014 IDLE: s_cyc=s_stb=s_we=0, s_addr/s_din/s_dm=0, m0_ack=m1_ack=0.
REQ-015 GRANTn: s_addr, s_din, s_dm, s_cyc, s_stb, s_we SHALL follow the live mn_* inputs combinationally; s_ack SHALL route to mn_ack only; the other master's ack SHALL be 0.
REQ-016 m0_dout and m1_dout SHALL both equal s_dout unconditionally; only the ack qualifies the data.
REQ-017 Arbitration SHALL sample mn_cyc; the winner's state SHALL be entered on the next edge, giving 1 cycle of added request latency and 0 cycles of added ack latency.
REQ-018 The grant SHALL be held while the granted master keeps mn_cyc high, including across multiple stb/ack beats, so a locked read-modify-write sequence is never interleaved.
REQ-019 When the granted master's cyc is low in GRANTn, the next state SHALL be chosen by arbitration in the same cycle: GRANTm if any cyc is pending, otherwise IDLE. Back-to-back handoff SHALL therefore occur without an IDLE cycle.
REQ-020 If the granted master drops cyc before ack (abort), s_cyc/s_stb SHALL fall in the same cycle. An s_ack arriving in IDLE, or arriving after the grant has moved, SHALL be discarded and SHALL NOT reach either master.
REQ-021 A register last_grant SHALL record the master most recently granted and SHALL be updated on every entry to a GRANT state.
REQ-022 A request from the non-granted master SHALL never pre-empt the current grant.

Reset
REQ-023 While rstn=0, state SHALL be IDLE, last_grant SHALL be 1, and all outputs SHALL follow REQ-014 with dbg_grant=00.
REQ-024 Assertion of rstn mid-transaction SHALL immediately drop s_cyc/s_stb. Deassertion SHALL resume in IDLE with no ack issued for the aborted transfer.

Configuration
REQ-025 Macro WS_ARB_ROUND_ROBIN_EN defined: when both cyc are high during arbitration, the grant SHALL go to the master that is not last_grant.
REQ-026 Macro WS_ARB_ROUND_ROBIN_EN undefined: master 0 SHALL always win simultaneous requests, and master 1 SHALL be granted only when m0_cyc=0. last_grant SHALL still be maintained.

Verification
REQ-027 Scenario 1: reset, then m0_cyc=m0_stb=1, we=0, addr=0x00001000; slave acks 3 cycles after s_stb with s_dout=pattern A. Required: s_stb rises 1 cycle after m0_stb, m0_ack pulses once with m0_dout=A, and m1_ack stays 0.
REQ-028 Scenario 2: m0 and m1 both raise cyc in the same cycle, each holding it for 2 transfers. Required with WS_ARB_ROUND_ROBIN_EN defined: order is m0, m1, m0, m1 across repeated contention. Required with the macro undefined: m0 wins every contention.
REQ-029 Scenario 3: m1 raises cyc while m0 holds cyc across a write to 0x2000 followed by a read from 0x2000. Required: m1 receives no ack and s_addr never shows m1_addr until m0_cyc falls; handoff to GRANT1 occurs the next cycle with no IDLE gap.
REQ-030 Scenario 4: m0 drops cyc 1 cycle after stb, then the slave asserts ack 2 cycles later. Required: s_cyc falls the same cycle as m0_cyc, the late ack is discarded, and dbg_grant=00.
REQ-031 Scenario 5: rstn is pulsed low during a GRANT1 write with we=1 and dm=all ones. Required: s_cyc=0 asynchronously, dbg_grant=00, and after release an m0 request is granted first.
